// File: rtl/bouncer_pkg.sv
// Shared types for the multi-box bouncer: sweep FSM states, width defaults and
// the per-box power-on placement.
package bouncer_pkg;

   localparam int COORD_W_DEF = 10;
   localparam int SPEED_W_DEF = 3;

   typedef enum logic {IDLE, SWEEP} state_t;

   typedef struct packed {
      logic [31:0] x;
      logic [31:0] y;
      logic        dx;
      logic        dy;
   } box_init_t;

   // Boxes start spread along the diagonal; even boxes head right, odd boxes left, all head down.
   function automatic box_init_t box_reset(input int i, input int n_box,
                                           input int h_res, input int v_res);
      box_init_t r;
      r.x  = 32'(i * (h_res / n_box));
      r.y  = 32'(i * (v_res / n_box));
      r.dx = ((i % 2) == 0);
      r.dy = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/box_hit_cmp.sv
// Combinational test of whether the scanned pixel falls inside one box.
// Zero latency; no flow control.
module box_hit_cmp
   import bouncer_pkg::*;
#(
   parameter int COORD_W = COORD_W_DEF,
   parameter int BOX_W   = 32,
   parameter int BOX_H   = 32
)(
   input  logic [COORD_W-1:0] box_x,
   input  logic [COORD_W-1:0] box_y,
   input  logic [COORD_W-1:0] pix_x,
   input  logic [COORD_W-1:0] pix_y,
   output logic               hit
);

   logic [COORD_W:0] x_end;
   logic [COORD_W:0] y_end;

   // One extra bit so a box touching the far edge cannot wrap its end coordinate.
   assign x_end = {1'b0, box_x} + (COORD_W+1)'(BOX_W);
   assign y_end = {1'b0, box_y} + (COORD_W+1)'(BOX_H);

   assign hit = (pix_x >= box_x) && ({1'b0, pix_x} < x_end) &&
                (pix_y >= box_y) && ({1'b0, pix_y} < y_end);

endmodule

// File: rtl/multi_box_bouncer.sv
// N boxes bouncing off the frame edges, updated one box per cycle after frame_tick.
// Hit outputs lag pix_x/pix_y by one cycle; ticks arriving while busy or paused are dropped.
module multi_box_bouncer
   import bouncer_pkg::*;
#(
   parameter int N_BOX   = 4,
   parameter int H_RES   = 640,
   parameter int V_RES   = 480,
   parameter int BOX_W   = 32,
   parameter int BOX_H   = 32,
   parameter int COORD_W = COORD_W_DEF,
   parameter int SPEED_W = SPEED_W_DEF
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     frame_tick,
   input  logic                     pause,
   input  logic [SPEED_W-1:0]       speed,
   input  logic [COORD_W-1:0]       pix_x,
   input  logic [COORD_W-1:0]       pix_y,
   output logic [N_BOX-1:0]         pix_hit,
   output logic                     pix_any,
   output logic [$clog2(N_BOX):0]   box_id,
   output logic [N_BOX-1:0]         bounce_evt,
   output logic                     busy
);

   localparam int ID_W = $clog2(N_BOX) + 1;
   localparam int K_W  = (N_BOX > 1) ? $clog2(N_BOX) : 1;
   localparam logic [K_W-1:0]     K_LAST = K_W'(N_BOX - 1);
   localparam logic [COORD_W-1:0] X_LIM  = COORD_W'(H_RES - BOX_W);
   localparam logic [COORD_W-1:0] Y_LIM  = COORD_W'(V_RES - BOX_H);

   typedef struct packed {
      logic               flip;
      logic               dir;
      logic [COORD_W-1:0] pos;
   } axis_t;

   // dir=1 moves toward lim, dir=0 toward 0; a step that would reach or pass an edge clamps and reflects.
   function automatic axis_t axis_step(input logic [COORD_W-1:0] pos, input logic dir,
                                       input logic [SPEED_W-1:0] spd,
                                       input logic [COORD_W-1:0] lim);
      axis_t            r;
      logic [COORD_W:0] p;
      logic [COORD_W:0] s;
      p      = {1'b0, pos};
      s      = (COORD_W+1)'(spd);
      r.flip = 1'b0;
      r.dir  = dir;
      r.pos  = pos;
      if (spd != '0) begin
         if (dir) begin
            if (p + s >= {1'b0, lim}) begin
               r.flip = 1'b1;
               r.dir  = 1'b0;
               r.pos  = lim;
            end else begin
               r.pos = pos + COORD_W'(spd);
            end
         end else begin
            if (p <= s) begin
               r.flip = 1'b1;
               r.dir  = 1'b1;
               r.pos  = '0;
            end else begin
               r.pos = pos - COORD_W'(spd);
            end
         end
      end
      return r;
   endfunction

   state_t               state_q, state_d;
   logic [K_W-1:0]       k_q;
   logic [SPEED_W-1:0]   spd_q;
   logic [COORD_W-1:0]   x_q [N_BOX];
   logic [COORD_W-1:0]   y_q [N_BOX];
   logic [N_BOX-1:0]     dx_q, dy_q;
   logic [COORD_W-1:0]   init_x [N_BOX];
   logic [COORD_W-1:0]   init_y [N_BOX];
   logic [N_BOX-1:0]     init_dx, init_dy;
   logic [N_BOX-1:0]     hit_c;
   logic [ID_W-1:0]      id_c;
   axis_t                nx, ny;
   logic                 start;

   for (genvar g = 0; g < N_BOX; g++) begin : g_box
      localparam box_init_t INIT = box_reset(g, N_BOX, H_RES, V_RES);
      assign init_x[g]  = INIT.x[COORD_W-1:0];
      assign init_y[g]  = INIT.y[COORD_W-1:0];
      assign init_dx[g] = INIT.dx;
      assign init_dy[g] = INIT.dy;

      box_hit_cmp #(
         .COORD_W (COORD_W),
         .BOX_W   (BOX_W),
         .BOX_H   (BOX_H)
      ) u_hit (
         .box_x (x_q[g]),
         .box_y (y_q[g]),
         .pix_x (pix_x),
         .pix_y (pix_y),
         .hit   (hit_c[g])
      );
   end

   assign start = frame_tick && !pause;
   assign busy  = (state_q == SWEEP);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = SWEEP;
         SWEEP:   if (k_q == K_LAST) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Single shared update datapath, steered to the box selected by k_q.
   always_comb begin
      nx         = axis_step(x_q[k_q], dx_q[k_q], spd_q, X_LIM);
      ny         = axis_step(y_q[k_q], dy_q[k_q], spd_q, Y_LIM);
      bounce_evt = '0;
      if (state_q == SWEEP) bounce_evt[k_q] = nx.flip | ny.flip;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         k_q     <= '0;
         spd_q   <= '0;
         dx_q    <= init_dx;
         dy_q    <= init_dy;
         for (int i = 0; i < N_BOX; i++) begin
            x_q[i] <= init_x[i];
            y_q[i] <= init_y[i];
         end
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && start) spd_q <= speed;
         if (state_q == SWEEP) begin
            k_q       <= (k_q == K_LAST) ? '0 : k_q + 1'b1;
            x_q[k_q]  <= nx.pos;
            y_q[k_q]  <= ny.pos;
            dx_q[k_q] <= nx.dir;
            dy_q[k_q] <= ny.dir;
         end
      end
   end

   always_comb begin
      id_c = '0;
      for (int i = N_BOX - 1; i >= 0; i--) begin
         if (hit_c[i]) id_c = ID_W'(i + 1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_hit <= '0;
         pix_any <= 1'b0;
         box_id  <= '0;
      end else begin
         pix_hit <= hit_c;
         pix_any <= |hit_c;
         box_id  <= id_c;
      end
   end

endmodule

// File: tb/tb_multi_box_bouncer.sv
// Directed bench: default 640x480 four-box instance plus a small 64x64 eight-box
// instance where overlaps and a true corner bounce are reachable quickly.
module tb_multi_box_bouncer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       frame_tick = 1'b0;
   logic       pause = 1'b0;
   logic [2:0] speed = '0;
   logic [9:0] pix_x = '0;
   logic [9:0] pix_y = '0;

   logic [3:0] pix_hit;
   logic       pix_any;
   logic [2:0] box_id;
   logic [3:0] bounce_evt;
   logic       busy;

   logic [7:0] s_pix_hit;
   logic       s_pix_any;
   logic [3:0] s_box_id;
   logic [7:0] s_bounce_evt;
   logic       s_busy;

   int n_tests = 0;
   int n_fail  = 0;
   int busy_cyc, s_busy_cyc;
   int ev_cnt [4];
   int s_ev_cnt [8];

   always #5 clk = ~clk;

   multi_box_bouncer dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .pause(pause), .speed(speed),
      .pix_x(pix_x), .pix_y(pix_y), .pix_hit(pix_hit), .pix_any(pix_any),
      .box_id(box_id), .bounce_evt(bounce_evt), .busy(busy)
   );

   multi_box_bouncer #(.N_BOX(8), .H_RES(64), .V_RES(64)) dut_sm (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .pause(pause), .speed(speed),
      .pix_x(pix_x), .pix_y(pix_y), .pix_hit(s_pix_hit), .pix_any(s_pix_any),
      .box_id(s_box_id), .bounce_evt(s_bounce_evt), .busy(s_busy)
   );

   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) if (bounce_evt[i]) ev_cnt[i]++;
      for (int j = 0; j < 8; j++) if (s_bounce_evt[j]) s_ev_cnt[j]++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // One accepted (or dropped) frame tick, then a fixed observation window.
   task automatic run_tick(input logic [2:0] spd);
      @(negedge clk);
      speed      = spd;
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      busy_cyc   = 0;
      s_busy_cyc = 0;
      for (int c = 0; c < 12; c++) begin
         if (busy) busy_cyc++;
         if (s_busy) s_busy_cyc++;
         @(negedge clk);
      end
   endtask

   function automatic int ev_sum();
      return ev_cnt[0] + ev_cnt[1] + ev_cnt[2] + ev_cnt[3];
   endfunction

   typedef struct {
      logic [9:0] px;
      logic [9:0] py;
      logic [3:0] hit;
      logic [2:0] id;
      logic [7:0] shit;
      logic [3:0] sid;
   } vec_t;

   vec_t vt [11];

   initial begin
      int b;

      vt[0]  = '{10'd0,   10'd0,   4'b0001, 3'd1, 8'h01, 4'd1};
      vt[1]  = '{10'd32,  10'd0,   4'b0000, 3'd0, 8'h00, 4'd0};
      vt[2]  = '{10'd31,  10'd31,  4'b0001, 3'd1, 8'h0F, 4'd1};
      vt[3]  = '{10'd40,  10'd40,  4'b0000, 3'd0, 8'h3C, 4'd3};
      vt[4]  = '{10'd160, 10'd120, 4'b0010, 3'd2, 8'h00, 4'd0};
      vt[5]  = '{10'd191, 10'd151, 4'b0010, 3'd2, 8'h00, 4'd0};
      vt[6]  = '{10'd192, 10'd151, 4'b0000, 3'd0, 8'h00, 4'd0};
      vt[7]  = '{10'd511, 10'd391, 4'b1000, 3'd4, 8'h00, 4'd0};
      vt[8]  = '{10'd87,  10'd87,  4'b0000, 3'd0, 8'h80, 4'd8};
      vt[9]  = '{10'd340, 10'd260, 4'b0100, 3'd3, 8'h00, 4'd0};
      vt[10] = '{10'd639, 10'd479, 4'b0000, 3'd0, 8'h00, 4'd0};

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("rst busy", busy, 0);
      check("rst pix_hit", pix_hit, 0);
      check("rst box_id", box_id, 0);
      check("rst pix_any", pix_any, 0);
      check("rst bounce_evt", bounce_evt, 0);
      check("rst s_busy", s_busy, 0);
      rst = 1'b0;
      @(negedge clk);
      check("rst x1", dut.x_q[1], 160);
      check("rst y1", dut.y_q[1], 120);
      check("rst dx1", dut.dx_q[1], 0);
      check("rst dy1", dut.dy_q[1], 1);
      check("rst dx0", dut.dx_q[0], 1);
      check("rst x3", dut.x_q[3], 480);
      check("rst y3", dut.y_q[3], 360);
      check("rst sm x7", dut_sm.x_q[7], 56);

      // Scan: drive a new pixel each cycle; outputs must still reflect the previous one.
      for (int i = 0; i <= 11; i++) begin
         @(negedge clk);
         if (i < 11) begin
            pix_x = vt[i].px;
            pix_y = vt[i].py;
         end
         #1;
         if (i > 0) begin
            check($sformatf("scan%0d hit", i-1), pix_hit, vt[i-1].hit);
            check($sformatf("scan%0d id", i-1), box_id, vt[i-1].id);
            check($sformatf("scan%0d any", i-1), pix_any, |vt[i-1].hit);
            check($sformatf("scan%0d s_hit", i-1), s_pix_hit, vt[i-1].shit);
            check($sformatf("scan%0d s_id", i-1), s_box_id, vt[i-1].sid);
            check($sformatf("scan%0d s_any", i-1), s_pix_any, |vt[i-1].shit);
         end
      end

      // Plain step
      b = ev_sum();
      run_tick(3'd2);
      check("step busy len", busy_cyc, 4);
      check("step sm busy len", s_busy_cyc, 8);
      check("step x0", dut.x_q[0], 2);
      check("step y0", dut.y_q[0], 2);
      check("step x1", dut.x_q[1], 158);
      check("step y1", dut.y_q[1], 122);
      check("step no bounce", ev_sum() - b, 0);

      // Right edge: 2 + 86*7 = 604, +2 = 606, +3 reaches 608
      for (int t = 0; t < 86; t++) run_tick(3'd7);
      run_tick(3'd2);
      check("right pre x0", dut.x_q[0], 606);
      check("right pre dx0", dut.dx_q[0], 1);
      b = ev_cnt[0];
      run_tick(3'd3);
      check("right x0", dut.x_q[0], 608);
      check("right dx0", dut.dx_q[0], 0);
      check("right y0", dut.y_q[0], 289);
      check("right dy0", dut.dy_q[0], 0);
      check("right bounce0 pulses", ev_cnt[0] - b, 1);

      // Left edge: 160 - 22*7 = 6, -4 = 2, then speed 3 reflects
      do_reset();
      b = ev_cnt[1];
      for (int t = 0; t < 22; t++) run_tick(3'd7);
      run_tick(3'd4);
      check("left pre x1", dut.x_q[1], 2);
      check("left pre bounce1", ev_cnt[1] - b, 0);
      b = ev_cnt[1];
      run_tick(3'd3);
      check("left x1", dut.x_q[1], 0);
      check("left dx1", dut.dx_q[1], 1);
      check("left y1", dut.y_q[1], 281);
      check("left bounce1 pulses", ev_cnt[1] - b, 1);

      // Corner on the 64x64 instance: box0 runs the diagonal into (32,32)
      do_reset();
      b = s_ev_cnt[0];
      for (int t = 0; t < 31; t++) run_tick(3'd1);
      check("corner pre x0", dut_sm.x_q[0], 31);
      check("corner pre y0", dut_sm.y_q[0], 31);
      check("corner pre bounce", s_ev_cnt[0] - b, 0);
      b = s_ev_cnt[0];
      run_tick(3'd1);
      check("corner x0", dut_sm.x_q[0], 32);
      check("corner y0", dut_sm.y_q[0], 32);
      check("corner dx0", dut_sm.dx_q[0], 0);
      check("corner dy0", dut_sm.dy_q[0], 0);
      check("corner single pulse", s_ev_cnt[0] - b, 1);

      // Pause and zero speed
      do_reset();
      pause = 1'b1;
      run_tick(3'd3);
      pause = 1'b0;
      check("pause busy", busy_cyc, 0);
      check("pause x0", dut.x_q[0], 0);
      check("pause y1", dut.y_q[1], 120);
      b = ev_sum();
      run_tick(3'd0);
      check("spd0 busy len", busy_cyc, 4);
      check("spd0 x0", dut.x_q[0], 0);
      check("spd0 x1", dut.x_q[1], 160);
      check("spd0 no bounce", ev_sum() - b, 0);

      // Tick while busy is dropped; speed change mid-sweep is ignored
      @(negedge clk);
      speed = 3'd2;
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      speed = 3'd7;
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      busy_cyc = 0;
      for (int c = 0; c < 12; c++) begin
         if (busy) busy_cyc++;
         @(negedge clk);
      end
      check("busy tick dropped", busy_cyc, 2);
      check("latched x0", dut.x_q[0], 2);
      check("latched y0", dut.y_q[0], 2);
      check("latched x3", dut.x_q[3], 478);
      check("latched y3", dut.y_q[3], 362);

      // Reset mid-sweep discards the partial update
      @(negedge clk);
      speed = 3'd5;
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      @(negedge clk);
      check("midrst busy before", busy, 1);
      #2 rst = 1'b1;
      #1;
      check("midrst busy", busy, 0);
      check("midrst bounce_evt", bounce_evt, 0);
      @(negedge clk);
      rst = 1'b0;
      check("midrst x0", dut.x_q[0], 0);
      check("midrst y0", dut.y_q[0], 0);
      check("midrst x1", dut.x_q[1], 160);
      check("midrst dx1", dut.dx_q[1], 0);
      @(negedge clk);
      @(negedge clk);
      check("midrst idle", busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
